// File: rtl/fcs_pkg.sv
// rtl/fcs_pkg.sv - shared encodings and defaults for the fire control sequencer
package fcs_pkg;

   // Sequencer state encodings (FCS_state output values)
   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_SEARCH   = 3'd1;
   localparam logic [2:0] ST_TRACK    = 3'd2;
   localparam logic [2:0] ST_ENGAGE   = 3'd3;
   localparam logic [2:0] ST_COOLDOWN = 3'd4;
   localparam logic [2:0] ST_LOCKOUT  = 3'd5;

   // Tracking unit reports idle with this code; scans are only issued then
   localparam logic [1:0] ARTAU_IDLE = 2'b00;

   // Default parameter values
   localparam int DEF_SCAN_PERIOD     = 50;
   localparam int DEF_LOCK_CYCLES     = 3;
   localparam int DEF_COOLDOWN_CYCLES = 20;
   localparam int DEF_MAX_ROUNDS      = 4;

   // Width of the shared scan/cooldown timer
   localparam int TMR_W = 16;

   // A timer that starts at 0 and must span N cycles stops at N-1
   function automatic logic [TMR_W-1:0] term_count(input int cycles);
      return TMR_W'(cycles - 1);
   endfunction

endpackage

// File: rtl/fcs_timer.sv
// rtl/fcs_timer.sv - saturating cycle timer with clear, enable and terminal compare
module fcs_timer
   import fcs_pkg::*;
#(
   parameter int W = TMR_W
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         i_clear,
   input  logic         i_enable,
   input  logic [W-1:0] i_terminal,
   output logic         o_done
);

   logic [W-1:0] r_count;
   logic         w_done;

   // Terminal reached (>= tolerates a terminal value lowered while counting)
   assign w_done = (r_count >= i_terminal);
   assign o_done = w_done;

   // Count up to the terminal value and hold there until cleared
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && !w_done) begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule

// File: rtl/fire_control_sequencer.sv
// rtl/fire_control_sequencer.sv - search/track/engage sequencer for the weapon fire request
module fire_control_sequencer
   import fcs_pkg::*;
#(
   parameter int SCAN_PERIOD     = DEF_SCAN_PERIOD,
   parameter int LOCK_CYCLES     = DEF_LOCK_CYCLES,
   parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
   parameter int MAX_ROUNDS      = DEF_MAX_ROUNDS
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        master_arm,
   input  logic        threat_detected,
   input  logic        safe_to_engage,
   input  logic        emergency_landing_alert,
   input  logic [1:0]  ARTAU_state,
   input  logic [31:0] distance_to_target,
   input  logic [31:0] min_engage_distance,
   input  logic        fire_ack,
   output logic        scan_for_target,
   output logic        fire_request,
   output logic        engagement_abort,
   output logic [2:0]  rounds_remaining,
   output logic [2:0]  lock_count,
   output logic [2:0]  FCS_state
);

   localparam logic [2:0]       LOCK_MAX   = 3'(LOCK_CYCLES);
   localparam logic [2:0]       ROUNDS_MAX = 3'(MAX_ROUNDS);
   localparam logic [TMR_W-1:0] SCAN_TERM  = term_count(SCAN_PERIOD);
   localparam logic [TMR_W-1:0] COOL_TERM  = term_count(COOLDOWN_CYCLES);

   logic [2:0]       r_state;
   logic [2:0]       r_lock;
   logic [2:0]       r_rounds;
   logic             r_fire;
   logic             r_scan;
   logic             r_abort;

   logic [2:0]       w_next_state;
   logic [2:0]       w_next_lock;
   logic [2:0]       w_next_rounds;
   logic             w_next_fire;
   logic             w_scan_fire;
   logic             w_abort;
   logic             w_global_exit;
   logic             w_qualify;
   logic [3:0]       w_lock_inc;
   logic             w_tmr_clear;
   logic             w_tmr_done;
   logic [TMR_W-1:0] w_tmr_term;

   assign w_global_exit = (r_state != ST_IDLE) && (emergency_landing_alert || !master_arm);
   assign w_qualify     = threat_detected && safe_to_engage &&
                          (distance_to_target >= min_engage_distance);
   assign w_lock_inc    = {1'b0, r_lock} + 4'd1;

   // One timer serves both SEARCH (scan period) and COOLDOWN; it restarts on every
   // state change and after each scan, and is held at zero in other states
   assign w_tmr_term  = (r_state == ST_COOLDOWN) ? COOL_TERM : SCAN_TERM;
   assign w_tmr_clear = (w_next_state != r_state) || w_scan_fire ||
                        !((r_state == ST_SEARCH) || (r_state == ST_COOLDOWN));

   fcs_timer #(
      .W (TMR_W)
   ) u_timer (
      .CLK        (CLK),
      .RST        (RST),
      .i_clear    (w_tmr_clear),
      .i_enable   (1'b1),
      .i_terminal (w_tmr_term),
      .o_done     (w_tmr_done)
   );

   // Next-state and next-output decode; arm/alert override everything outside IDLE
   always_comb begin
      w_next_state  = r_state;
      w_next_lock   = r_lock;
      w_next_rounds = r_rounds;
      w_next_fire   = r_fire;
      w_scan_fire   = 1'b0;
      w_abort       = 1'b0;
      if (w_global_exit) begin
         w_next_state  = ST_IDLE;
         w_next_lock   = 3'd0;
         w_next_rounds = ROUNDS_MAX;
         w_next_fire   = 1'b0;
         w_abort       = (r_state == ST_ENGAGE);
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_next_lock   = 3'd0;
               w_next_rounds = ROUNDS_MAX;
               w_next_fire   = 1'b0;
               if (master_arm && !emergency_landing_alert) begin
                  w_next_state = ST_SEARCH;
               end
            end
            ST_SEARCH: begin
               if (threat_detected) begin
                  w_next_state = ST_TRACK;
                  w_next_lock  = 3'd0;
               end else if (w_tmr_done && (ARTAU_state == ARTAU_IDLE)) begin
                  w_scan_fire = 1'b1;
               end
            end
            ST_TRACK: begin
               if (!threat_detected) begin
                  w_next_state = ST_SEARCH;
                  w_next_lock  = 3'd0;
               end else if (w_qualify) begin
                  if (w_lock_inc >= {1'b0, LOCK_MAX}) begin
                     w_next_lock  = LOCK_MAX;
                     w_next_state = ST_ENGAGE;
                     w_next_fire  = 1'b1;
                  end else begin
                     w_next_lock = w_lock_inc[2:0];
                  end
               end
            end
            ST_ENGAGE: begin
               // An acknowledge in the same cycle as a safety drop still counts the round
               if (fire_ack) begin
                  w_next_rounds = r_rounds - 3'd1;
                  w_next_fire   = 1'b0;
                  w_next_state  = (r_rounds == 3'd1) ? ST_LOCKOUT : ST_COOLDOWN;
               end else if (!safe_to_engage) begin
                  w_abort      = 1'b1;
                  w_next_state = ST_SEARCH;
                  w_next_lock  = 3'd0;
                  w_next_fire  = 1'b0;
               end else begin
                  w_next_fire = 1'b1;
               end
            end
            ST_COOLDOWN: begin
               if (w_tmr_done) begin
                  w_next_lock  = 3'd0;
                  w_next_state = threat_detected ? ST_TRACK : ST_SEARCH;
               end
            end
            ST_LOCKOUT: begin
               w_next_fire = 1'b0;
            end
            default: begin
               w_next_state = ST_IDLE;
               w_next_fire  = 1'b0;
            end
         endcase
      end
   end

   // State and registered outputs; reset forces IDLE without an abort pulse
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state  <= ST_IDLE;
         r_lock   <= 3'd0;
         r_rounds <= ROUNDS_MAX;
         r_fire   <= 1'b0;
         r_scan   <= 1'b0;
         r_abort  <= 1'b0;
      end else begin
         r_state  <= w_next_state;
         r_lock   <= w_next_lock;
         r_rounds <= w_next_rounds;
         r_fire   <= w_next_fire;
         r_scan   <= w_scan_fire;
         r_abort  <= w_abort;
      end
   end

   assign scan_for_target  = r_scan;
   assign fire_request     = r_fire;
   assign engagement_abort = r_abort;
   assign rounds_remaining = r_rounds;
   assign lock_count       = r_lock;
   assign FCS_state        = r_state;

endmodule

// File: tb/tb_fire_control_sequencer.sv
// tb/tb_fire_control_sequencer.sv - self-checking bench for fire_control_sequencer
module tb_fire_control_sequencer;

   localparam int EV_NONE  = 0;
   localparam int EV_SCAN  = 1;
   localparam int EV_FIRE  = 2;
   localparam int EV_ABORT = 3;

   typedef struct {
      int kind;
      int cyc;
   } evt_t;

   logic        CLK = 1'b0;
   logic        RST;
   logic        master_arm;
   logic        threat_detected;
   logic        safe_to_engage;
   logic        emergency_landing_alert;
   logic [1:0]  ARTAU_state;
   logic [31:0] distance_to_target;
   logic [31:0] min_engage_distance;
   logic        fire_ack;
   logic        scan_for_target;
   logic        fire_request;
   logic        engagement_abort;
   logic [2:0]  rounds_remaining;
   logic [2:0]  lock_count;
   logic [2:0]  FCS_state;

   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   logic prev_fire = 1'b0;
   evt_t exp_q[$];

   fire_control_sequencer dut (
      .CLK                     (CLK),
      .RST                     (RST),
      .master_arm              (master_arm),
      .threat_detected         (threat_detected),
      .safe_to_engage          (safe_to_engage),
      .emergency_landing_alert (emergency_landing_alert),
      .ARTAU_state             (ARTAU_state),
      .distance_to_target      (distance_to_target),
      .min_engage_distance     (min_engage_distance),
      .fire_ack                (fire_ack),
      .scan_for_target         (scan_for_target),
      .fire_request            (fire_request),
      .engagement_abort        (engagement_abort),
      .rounds_remaining        (rounds_remaining),
      .lock_count              (lock_count),
      .FCS_state               (FCS_state)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic push_evt(input int kind, input int at);
      evt_t e;
      e.kind = kind;
      e.cyc  = at;
      exp_q.push_back(e);
   endtask

   task automatic match_evt(input int kind);
      evt_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
      end else begin
         e.kind = EV_NONE;
         e.cyc  = -1;
      end
      check_eq("evt_kind", kind, e.kind);
      check_eq("evt_cycle", cyc, e.cyc);
   endtask

   // Output event monitor: scan pulses, abort pulses and fire_request rising edges
   always @(negedge CLK) begin
      if (scan_for_target) match_evt(EV_SCAN);
      if (engagement_abort) match_evt(EV_ABORT);
      if (fire_request && !prev_fire) match_evt(EV_FIRE);
      prev_fire = fire_request;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      int c;
      RST = 1'b1;
      master_arm = 1'b0;
      threat_detected = 1'b0;
      safe_to_engage = 1'b0;
      emergency_landing_alert = 1'b0;
      ARTAU_state = 2'b00;
      distance_to_target = 32'd0;
      min_engage_distance = 32'd0;
      fire_ack = 1'b0;
      tick(3);
      RST = 1'b0;
      check_eq("rst_state", FCS_state, 0);
      check_eq("rst_rounds", rounds_remaining, 4);
      check_eq("rst_lock", lock_count, 0);
      check_eq("rst_fire", fire_request, 0);

      // Periodic scans, then a scan held off by a busy tracking unit
      tick(2);
      c0 = cyc;
      master_arm = 1'b1;
      push_evt(EV_SCAN, c0 + 51);
      push_evt(EV_SCAN, c0 + 101);
      tick(1);
      check_eq("arm_search", FCS_state, 1);
      tick(c0 + 101 - cyc);
      ARTAU_state = 2'b10;
      push_evt(EV_SCAN, c0 + 171);
      tick(c0 + 170 - cyc);
      ARTAU_state = 2'b00;
      tick(2);
      check_eq("scan_q_drained", exp_q.size(), 0);

      // Lock on, engage, acknowledge after five cycles, cooldown
      c = cyc;
      threat_detected = 1'b1;
      safe_to_engage = 1'b1;
      distance_to_target = 32'd1000;
      min_engage_distance = 32'd500;
      push_evt(EV_FIRE, c + 4);
      tick(1);
      check_eq("trk_state", FCS_state, 2);
      check_eq("trk_lock0", lock_count, 0);
      tick(1);
      check_eq("trk_lock1", lock_count, 1);
      tick(2);
      check_eq("eng_lock3", lock_count, 3);
      check_eq("eng_state", FCS_state, 3);
      tick(4);
      check_eq("fire_held", fire_request, 1);
      fire_ack = 1'b1;
      tick(1);
      fire_ack = 1'b0;
      check_eq("ack_rounds", rounds_remaining, 3);
      check_eq("ack_state", FCS_state, 4);
      check_eq("ack_fire", fire_request, 0);
      tick(4);
      fire_ack = 1'b1;
      tick(1);
      fire_ack = 1'b0;
      check_eq("cd_ack_ignored", rounds_remaining, 3);
      tick(14);
      check_eq("cd_last", FCS_state, 4);
      tick(1);
      check_eq("cd_to_track", FCS_state, 2);
      check_eq("cd_lock_clr", lock_count, 0);

      // Remaining rounds until lockout
      for (int r = 2; r <= 4; r++) begin
         c = cyc;
         push_evt(EV_FIRE, c + 3);
         tick(3);
         check_eq("rnd_engage", FCS_state, 3);
         fire_ack = 1'b1;
         tick(1);
         fire_ack = 1'b0;
         check_eq("rnd_rounds", rounds_remaining, 4 - r);
         if (r < 4) begin
            check_eq("rnd_cooldown", FCS_state, 4);
            tick(20);
            check_eq("rnd_track", FCS_state, 2);
         end else begin
            check_eq("rnd_lockout", FCS_state, 5);
         end
      end
      tick(60);
      check_eq("lockout_hold", FCS_state, 5);
      check_eq("lockout_fire", fire_request, 0);
      master_arm = 1'b0;
      tick(1);
      check_eq("disarm_idle", FCS_state, 0);
      tick(1);
      check_eq("disarm_rounds", rounds_remaining, 4);

      // Short range holds the lock; exact minimum qualifies; safety drop aborts
      threat_detected = 1'b0;
      distance_to_target = 32'd400;
      min_engage_distance = 32'd500;
      master_arm = 1'b1;
      tick(1);
      threat_detected = 1'b1;
      tick(11);
      check_eq("short_state", FCS_state, 2);
      check_eq("short_lock", lock_count, 0);
      distance_to_target = 32'd500;
      c = cyc;
      push_evt(EV_FIRE, c + 3);
      tick(3);
      check_eq("eqmin_engage", FCS_state, 3);
      safe_to_engage = 1'b0;
      push_evt(EV_ABORT, cyc + 1);
      tick(1);
      check_eq("abort_state", FCS_state, 1);
      check_eq("abort_lock", lock_count, 0);
      check_eq("abort_fire", fire_request, 0);

      // Unsigned compare above 2^31; ack wins over a simultaneous safety drop
      safe_to_engage = 1'b1;
      distance_to_target = 32'h8000_0000;
      min_engage_distance = 32'd1;
      c = cyc;
      push_evt(EV_FIRE, c + 4);
      tick(4);
      check_eq("big_engage", FCS_state, 3);
      safe_to_engage = 1'b0;
      fire_ack = 1'b1;
      tick(1);
      fire_ack = 1'b0;
      safe_to_engage = 1'b1;
      check_eq("ackwin_state", FCS_state, 4);
      check_eq("ackwin_rounds", rounds_remaining, 3);

      // Reset in the middle of cooldown
      tick(5);
      RST = 1'b1;
      tick(1);
      RST = 1'b0;
      check_eq("mrst_state", FCS_state, 0);
      check_eq("mrst_rounds", rounds_remaining, 4);
      check_eq("mrst_lock", lock_count, 0);
      check_eq("mrst_fire", fire_request, 0);
      check_eq("mrst_scan", scan_for_target, 0);
      check_eq("mrst_abort", engagement_abort, 0);

      // Emergency alert while engaged
      distance_to_target = 32'd1000;
      min_engage_distance = 32'd500;
      c = cyc;
      push_evt(EV_FIRE, c + 5);
      tick(5);
      check_eq("ela_engage", FCS_state, 3);
      emergency_landing_alert = 1'b1;
      push_evt(EV_ABORT, cyc + 1);
      tick(1);
      check_eq("ela_idle", FCS_state, 0);
      check_eq("ela_fire", fire_request, 0);
      tick(1);
      check_eq("ela_stay_idle", FCS_state, 0);
      check_eq("ela_rounds", rounds_remaining, 4);
      emergency_landing_alert = 1'b0;
      master_arm = 1'b0;
      tick(2);
      check_eq("evt_q_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
